csr_access_sequencer: RTL and testbench

Initiator side of the CSR read/write port: executes one Zicsr instruction (CSRRW/CSRRS/CSRRC and the immediate forms) as a read–modify–write sequence against the CSR register-file responder. It sits between the execute stage and the CSR block. It issues the read strobe, captures the old value, computes and issues the write, checks the responder's fault flag, then returns the old value for rd.

---
 rtl/csr_access_sequencer_if.sv | 38 +++
 rtl/csr_access_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_csr_access_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_access_sequencer_if.sv
// CSR read/write port between the access sequencer (master) and the
// CSR register-file responder (slave). Read and write strobes share one
// fault return line; the responder answers one cycle after either strobe.
interface csr_access_sequencer_if #(
    parameter int XLEN          = 32,
    parameter int CSR_ADDR_BITS = 12
);
    logic                     csr_read_enable;
    logic [CSR_ADDR_BITS-1:0] csr_read_addr;
    logic                     csr_read_en_in;
    logic [XLEN-1:0]          csr_read_data_in;
    logic                     csr_fault_in;
    logic                     csr_write_enable;
    logic [CSR_ADDR_BITS-1:0] csr_write_addr;
    logic [XLEN-1:0]          csr_write_data;

    modport master (
        output csr_read_enable,
        output csr_read_addr,
        input  csr_read_en_in,
        input  csr_read_data_in,
        input  csr_fault_in,
        output csr_write_enable,
        output csr_write_addr,
        output csr_write_data
    );

    modport slave (
        input  csr_read_enable,
        input  csr_read_addr,
        output csr_read_en_in,
        output csr_read_data_in,
        output csr_fault_in,
        input  csr_write_enable,
        input  csr_write_addr,
        input  csr_write_data
    );
endinterface

// File: rtl/csr_access_sequencer.sv
// Zicsr read-modify-write sequencer. Accepts one CSRRW/RS/RC (register or
// immediate form) from execute, reads the old CSR value, issues the merged
// write, checks the responder's fault flag and returns the old value for rd.
// All outputs are registered and computed together with the next state, so
// each strobe/pulse is visible in exactly the cycle its state is occupied.
module csr_access_sequencer #(
    parameter int XLEN          = 32,
    parameter int CSR_ADDR_BITS = 12,
    parameter int RD_TIMEOUT    = 15
) (
    input  logic                     clk,
    input  logic                     sync_reset,
    input  logic                     start,
    input  logic [2:0]               funct3,
    input  logic [CSR_ADDR_BITS-1:0] csr_addr,
    input  logic [XLEN-1:0]          rs1_value,
    input  logic [4:0]               rs1_field,
    input  logic [4:0]               rd_index,
    output logic                     busy,
    output logic                     done,
    output logic                     illegal,
    output logic                     rd_we,
    output logic [4:0]               rd_index_out,
    output logic [XLEN-1:0]          rd_data,
    csr_access_sequencer_if.master   csr_bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RWAIT,
        S_WR,
        S_WCHK,
        S_DONE
    } state_t;

    // Last RWAIT count that may still see a response; one more wait cycle
    // and the read is declared lost.
    localparam logic [3:0] TIMEOUT_LAST = 4'(RD_TIMEOUT);

    state_t                   state_q;
    logic [1:0]               op_q;        // 01 write, 10 set, 11 clear
    logic [CSR_ADDR_BITS-1:0] addr_q;
    logic [XLEN-1:0]          src_q;
    logic [XLEN-1:0]          old_q;       // stays 0 when the read is skipped
    logic                     rs1_zero_q;
    logic [3:0]               wait_cnt_q;

    logic                     busy_q;
    logic                     done_q;
    logic                     illegal_q;
    logic                     rd_we_q;
    logic [4:0]               rd_index_q;
    logic [XLEN-1:0]          rd_data_q;
    logic                     rd_en_q;
    logic [CSR_ADDR_BITS-1:0] rd_addr_q;
    logic                     wr_en_q;
    logic [CSR_ADDR_BITS-1:0] wr_addr_q;
    logic [XLEN-1:0]          wr_data_q;

    logic [XLEN-1:0]          src_d;

    // Immediate forms use the zero-extended uimm in the rs1 field.
    assign src_d = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_field} : rs1_value;

    function automatic logic [XLEN-1:0] merge_wdata(
        input logic [1:0]      op,
        input logic [XLEN-1:0] old_v,
        input logic [XLEN-1:0] src_v
    );
        case (op)
            2'b10:   merge_wdata = old_v | src_v;
            2'b11:   merge_wdata = old_v & ~src_v;
            default: merge_wdata = src_v;
        endcase
    endfunction

    // Sequencer FSM with registered strobes, completion pulse and result.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            src_q        <= '0;
            old_q        <= '0;
            rs1_zero_q   <= 1'b0;
            wait_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
            rd_we_q      <= 1'b0;
            rd_index_q   <= '0;
            rd_data_q    <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            // Pulses and done-qualified results default low every cycle.
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            rd_we_q   <= 1'b0;
            rd_data_q <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q       <= funct3[1:0];
                        addr_q     <= csr_addr;
                        src_q      <= src_d;
                        old_q      <= '0;
                        rs1_zero_q <= (rs1_field == 5'd0);
                        rd_index_q <= rd_index;
                        wait_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        if (funct3[1:0] == 2'b00) begin
                            // Reserved encodings fault without touching the CSR.
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            illegal_q <= 1'b1;
                        end else if (funct3[1:0] == 2'b01 && rd_index == 5'd0) begin
                            // Write with rd=x0 must not have read side effects.
                            state_q   <= S_WR;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= csr_addr;
                            wr_data_q <= src_d;
                        end else begin
                            state_q   <= S_RD;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= csr_addr;
                        end
                    end
                end

                S_RD: begin
                    state_q    <= S_RWAIT;
                    wait_cnt_q <= '0;
                end

                S_RWAIT: begin
                    if (csr_bus.csr_fault_in) begin
                        // Fault takes precedence over a simultaneous response.
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        illegal_q <= 1'b1;
                        rd_data_q <= old_q;
                    end else if (csr_bus.csr_read_en_in) begin
                        old_q <= csr_bus.csr_read_data_in;
                        if (op_q[1] && rs1_zero_q) begin
                            // Set/clear with a zero operand is a pure read.
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            rd_we_q   <= (rd_index_q != 5'd0);
                            rd_data_q <= csr_bus.csr_read_data_in;
                        end else begin
                            state_q   <= S_WR;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_q;
                            wr_data_q <= merge_wdata(op_q, csr_bus.csr_read_data_in, src_q);
                        end
                    end else if (wait_cnt_q == TIMEOUT_LAST) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        illegal_q <= 1'b1;
                        rd_data_q <= old_q;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end

                S_WR: begin
                    state_q <= S_WCHK;
                end

                S_WCHK: begin
                    // The responder flags a rejected write one cycle after the strobe.
                    state_q   <= S_DONE;
                    done_q    <= 1'b1;
                    illegal_q <= csr_bus.csr_fault_in;
                    rd_we_q   <= ~csr_bus.csr_fault_in & (rd_index_q != 5'd0);
                    rd_data_q <= old_q;
                end

                S_DONE: begin
                    // start is deliberately not sampled here.
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign illegal      = illegal_q;
    assign rd_we        = rd_we_q;
    assign rd_index_out = rd_index_q;
    assign rd_data      = rd_data_q;

    assign csr_bus.csr_read_enable  = rd_en_q;
    assign csr_bus.csr_read_addr    = rd_addr_q;
    assign csr_bus.csr_write_enable = wr_en_q;
    assign csr_bus.csr_write_addr   = wr_addr_q;
    assign csr_bus.csr_write_data   = wr_data_q;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Directed bench for csr_access_sequencer: a configurable CSR responder,
// one run per instruction with hand-computed cycle positions and values.
module tb_csr_access_sequencer;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic        start;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [31:0] rs1_value;
    logic [4:0]  rs1_field;
    logic [4:0]  rd_index;
    logic        busy, done, illegal, rd_we;
    logic [4:0]  rd_index_out;
    logic [31:0] rd_data;

    csr_access_sequencer_if #(.XLEN(32), .CSR_ADDR_BITS(12)) bus ();

    csr_access_sequencer #(.XLEN(32), .CSR_ADDR_BITS(12), .RD_TIMEOUT(15)) dut (
        .clk          (clk),
        .sync_reset   (sync_reset),
        .start        (start),
        .funct3       (funct3),
        .csr_addr     (csr_addr),
        .rs1_value    (rs1_value),
        .rs1_field    (rs1_field),
        .rd_index     (rd_index),
        .busy         (busy),
        .done         (done),
        .illegal      (illegal),
        .rd_we        (rd_we),
        .rd_index_out (rd_index_out),
        .rd_data      (rd_data),
        .csr_bus      (bus.master)
    );

    always #5 clk = ~clk;

    // Responder configuration, set before each run.
    logic [31:0] cfg_data   = '0;
    int          cfg_delay  = 0;
    logic        cfg_rfault = 1'b0;
    logic        cfg_wfault = 1'b0;
    logic        cfg_never  = 1'b0;
    int          pend       = 0;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural responder: answers one cycle after a strobe, plus cfg_delay.
    always @(posedge clk) begin
        bus.csr_read_en_in   <= 1'b0;
        bus.csr_read_data_in <= '0;
        bus.csr_fault_in     <= 1'b0;
        if (sync_reset) begin
            pend <= 0;
        end else if (bus.csr_read_enable) begin
            if (cfg_rfault) begin
                bus.csr_fault_in <= 1'b1;
            end else if (!cfg_never) begin
                if (cfg_delay == 0) begin
                    bus.csr_read_en_in   <= 1'b1;
                    bus.csr_read_data_in <= cfg_data;
                end else begin
                    pend <= cfg_delay;
                end
            end
        end else if (pend > 0) begin
            if (pend == 1) begin
                bus.csr_read_en_in   <= 1'b1;
                bus.csr_read_data_in <= cfg_data;
            end
            pend <= pend - 1;
        end
        if (!sync_reset && bus.csr_write_enable && cfg_wfault)
            bus.csr_fault_in <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction and follow it to its done pulse (bounded).
    task automatic run_op(
        input string       tag,
        input logic [2:0]  f3,
        input logic [11:0] addr,
        input logic [31:0] rs1v,
        input logic [4:0]  rs1f,
        input logic [4:0]  rdi,
        input int          e_rd_cyc,
        input int          e_wr_cyc,
        input logic [31:0] e_wdata,
        input int          e_done,
        input logic        e_ill,
        input logic        e_we,
        input logic [31:0] e_rdata
    );
        int          rd_cyc = 0, wr_cyc = 0, wr_cnt = 0, done_cyc = 0;
        logic        overlap = 1'b0, ill_s = 1'b0, we_s = 1'b0;
        logic [31:0] wdata_s = '0, rdata_s = '0;
        logic [11:0] raddr_s = '0, waddr_s = '0;
        logic [4:0]  rdidx_s = '0;
        @(negedge clk);
        funct3 = f3; csr_addr = addr; rs1_value = rs1v; rs1_field = rs1f; rd_index = rdi;
        start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (bus.csr_read_enable && bus.csr_write_enable) overlap = 1'b1;
            if (bus.csr_read_enable && rd_cyc == 0) begin
                rd_cyc = k; raddr_s = bus.csr_read_addr;
            end
            if (bus.csr_write_enable) begin
                wr_cnt++;
                if (wr_cyc == 0) begin
                    wr_cyc = k; wdata_s = bus.csr_write_data; waddr_s = bus.csr_write_addr;
                end
            end
            if (done) begin
                done_cyc = k; ill_s = illegal; we_s = rd_we; rdata_s = rd_data; rdidx_s = rd_index_out;
                break;
            end
        end
        check({tag, ".rd_cycle"}, 64'(rd_cyc), 64'(e_rd_cyc));
        check({tag, ".wr_cycle"}, 64'(wr_cyc), 64'(e_wr_cyc));
        check({tag, ".wr_count"}, 64'(wr_cnt), 64'(e_wr_cyc != 0));
        if (e_rd_cyc != 0) check({tag, ".rd_addr"}, 64'(raddr_s), 64'(addr));
        if (e_wr_cyc != 0) begin
            check({tag, ".wr_addr"}, 64'(waddr_s), 64'(addr));
            check({tag, ".wr_data"}, 64'(wdata_s), 64'(e_wdata));
        end
        check({tag, ".done_cycle"}, 64'(done_cyc), 64'(e_done));
        check({tag, ".illegal"}, 64'(ill_s), 64'(e_ill));
        check({tag, ".rd_we"}, 64'(we_s), 64'(e_we));
        check({tag, ".rd_data"}, 64'(rdata_s), 64'(e_rdata));
        check({tag, ".rd_index"}, 64'(rdidx_s), 64'(rdi));
        check({tag, ".overlap"}, 64'(overlap), 64'(0));
        $display("op %s f3=%b addr=0x%03h rd_cyc=%0d wr_cyc=%0d wdata=0x%08h done=%0d ill=%0b rd_we=%0b rd_data=0x%08h",
                 tag, f3, addr, rd_cyc, wr_cyc, wdata_s, done_cyc, ill_s, we_s, rdata_s);
    endtask

    initial begin
        int   done_early, done_cnt_after;
        logic ill5, done6, done7, ill7, wr_seen;
        sync_reset = 1'b1; start = 1'b0; funct3 = '0; csr_addr = '0;
        rs1_value = '0; rs1_field = '0; rd_index = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.done", 64'(done), 64'(0));
        check("reset.rd_en", 64'(bus.csr_read_enable), 64'(0));
        check("reset.wr_en", 64'(bus.csr_write_enable), 64'(0));
        check("reset.rd_data", 64'(rd_data), 64'(0));
        sync_reset = 1'b0;

        // CSRRS: 0x8 | 0x88
        cfg_data = 32'h0000_0008;
        run_op("csrrs", 3'b010, 12'h300, 32'h0000_0088, 5'd5, 5'd3,
               1, 3, 32'h0000_0088, 5, 1'b0, 1'b1, 32'h0000_0008);
        // CSRRCI uimm=8 (rs1_value must be ignored)
        cfg_data = 32'h0000_0888;
        run_op("csrrci", 3'b111, 12'h341, 32'hFFFF_FFFF, 5'd8, 5'd7,
               1, 3, 32'h0000_0880, 5, 1'b0, 1'b1, 32'h0000_0888);
        // CSRRCI uimm=0: read only
        run_op("csrrci0", 3'b111, 12'h341, 32'hFFFF_FFFF, 5'd0, 5'd7,
               1, 0, 32'h0, 3, 1'b0, 1'b1, 32'h0000_0888);
        // CSRRW rd=x0: write only
        run_op("csrrw0", 3'b001, 12'h305, 32'hDEAD_BEEF, 5'd9, 5'd0,
               0, 1, 32'hDEAD_BEEF, 3, 1'b0, 1'b0, 32'h0);
        // Read fault on unsupported address
        cfg_rfault = 1'b1;
        run_op("rdfault", 3'b010, 12'h7FF, 32'h1, 5'd1, 5'd4,
               1, 0, 32'h0, 3, 1'b1, 1'b0, 32'h0);
        cfg_rfault = 1'b0;
        // Write to read-only CSR faults in WCHK
        cfg_data = 32'h0000_1234; cfg_wfault = 1'b1;
        run_op("wrfault", 3'b001, 12'hF11, 32'h0000_5555, 5'd2, 5'd5,
               1, 3, 32'h0000_5555, 5, 1'b1, 1'b0, 32'h0000_1234);
        cfg_wfault = 1'b0;
        // Reserved funct3
        run_op("illf3", 3'b100, 12'h300, 32'h0, 5'd1, 5'd1,
               0, 0, 32'h0, 1, 1'b1, 1'b0, 32'h0);
        // CSRRSI with two extra wait cycles
        cfg_data = 32'h0000_0010; cfg_delay = 2;
        run_op("csrrsi_d2", 3'b110, 12'h344, 32'h0, 5'd3, 5'd6,
               1, 5, 32'h0000_0013, 7, 1'b0, 1'b1, 32'h0000_0010);
        cfg_delay = 0;
        // Responder never answers: 16 RWAIT cycles then illegal
        cfg_never = 1'b1;
        run_op("timeout", 3'b010, 12'h345, 32'h1, 5'd1, 5'd8,
               1, 0, 32'h0, 18, 1'b1, 1'b0, 32'h0);

        // Abort in RWAIT: reset for one cycle, then nothing must follow.
        @(negedge clk);
        funct3 = 3'b010; csr_addr = 12'h340; rs1_value = 32'h1; rs1_field = 5'd1; rd_index = 5'd2;
        start = 1'b1;
        @(negedge clk); start = 1'b0;          // RD
        @(negedge clk); sync_reset = 1'b1;      // RWAIT
        @(negedge clk); sync_reset = 1'b0;
        check("abort.busy", 64'(busy), 64'(0));
        done_cnt_after = 0; wr_seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done) done_cnt_after++;
            if (bus.csr_write_enable) wr_seen = 1'b1;
        end
        check("abort.done", 64'(done_cnt_after), 64'(0));
        check("abort.write", 64'(wr_seen), 64'(0));
        $display("op abort done_after=%0d write_seen=%0b", done_cnt_after, wr_seen);
        cfg_never = 1'b0;

        // Stray starts: start held high through busy and DONE, funct3 turned
        // illegal after acceptance; only the IDLE cycle after DONE may accept it.
        cfg_data = 32'h0000_00F0;
        @(negedge clk);
        funct3 = 3'b010; csr_addr = 12'h300; rs1_value = 32'h0F; rs1_field = 5'd1; rd_index = 5'd1;
        start = 1'b1;
        done_early = 0; ill5 = 1'b0; done6 = 1'b0; done7 = 1'b0; ill7 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) funct3 = 3'b000;
            if (k <= 5 && done) done_early++;
            if (k == 5) ill5 = illegal;
            if (k == 6) done6 = done;
            if (k == 7) begin done7 = done; ill7 = illegal; start = 1'b0; end
        end
        check("stray.done_count", 64'(done_early), 64'(1));
        check("stray.first_illegal", 64'(ill5), 64'(0));
        check("stray.idle_done", 64'(done6), 64'(0));
        check("stray.accept_done", 64'(done7), 64'(1));
        check("stray.accept_illegal", 64'(ill7), 64'(1));
        $display("op stray done_early=%0d done6=%0b done7=%0b ill7=%0b", done_early, done6, done7, ill7);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
